// File: rtl/adc_sample_decimator_if.sv
// Stream port carrying decimated samples toward the S2MM packetizer.
// The decimator drives the master side; the packetizer input is the slave side.
interface adc_sample_decimator_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adc_sample_decimator.sv
// Boxcar decimator: averages blocks of 2^k signed ADC samples and queues each
// sign-extended result in a small FIFO that drains over a stream port.
module adc_sample_decimator #(
  parameter int DATA_WIDTH = 18,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_SHIFT  = 12
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic signed [DATA_WIDTH-1:0]  adc_data,
  input  logic                          adc_valid,
  input  logic [31:0]                   config_reg,
  adc_sample_decimator_if.master        m_axis,
  output logic [31:0]                   overflow_counter,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int ACC_W = DATA_WIDTH + MAX_SHIFT;
  localparam int CNT_W = MAX_SHIFT + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int KW    = 4;

  logic                    enable;
  logic [KW-1:0]           ks;
  logic [KW-1:0]           k_active;
  logic [KW-1:0]           k_eff;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_last;
  logic                    last;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic [31:0]             res32;
  logic                    push_req;
  logic                    unused_cfg;

  assign unused_cfg = ^config_reg[30:4];
  assign enable     = config_reg[31];
  assign ks         = (config_reg[3:0] > KW'(MAX_SHIFT)) ? KW'(MAX_SHIFT) : config_reg[3:0];

  // A block takes its ratio from the config seen with its first sample.
  assign k_eff      = (cnt == '0) ? ks : k_active;
  assign cnt_last   = (CNT_W'(1) << k_eff) - CNT_W'(1);
  assign last       = !(cnt < cnt_last);

  assign sample_ext = {{MAX_SHIFT{adc_data[DATA_WIDTH-1]}}, adc_data};
  assign sum        = acc + sample_ext;
  assign shifted    = sum >>> k_eff;
  assign res32      = {{(32-ACC_W){shifted[ACC_W-1]}}, shifted};
  assign push_req   = adc_valid && enable && last;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      acc      <= '0;
      cnt      <= '0;
      k_active <= '0;
    end else begin
      if (cnt == '0)
        k_active <= ks;
      if (!enable) begin
        acc <= '0;
        cnt <= '0;
      end else if (adc_valid) begin
        if (last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign full = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign pop  = m_axis.tvalid && m_axis.tready;
  // A full FIFO still takes a result when the head leaves in the same cycle.
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  always_ff @(posedge aclk) begin
    if (push)
      mem[wr_ptr] <= res32;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)
      overflow_counter <= '0;
    else if (drop && (overflow_counter != '1))
      overflow_counter <= overflow_counter + 32'd1;
  end

  assign m_axis.tvalid = (fifo_level != '0);
  // Gate the head with tvalid so the uninitialised memory never shows after reset.
  assign m_axis.tdata  = m_axis.tvalid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_adc_sample_decimator.sv
// Directed bench for adc_sample_decimator: averaging, floor/sign, overflow,
// config clamping and mid-block change, disable and reset behaviour.
module tb_adc_sample_decimator;

  localparam logic [31:0] EN = 32'h8000_0000;

  logic        aclk = 1'b0;
  logic        areset;
  logic [17:0] adc_data;
  logic        adc_valid;
  logic [31:0] config_reg;
  logic [31:0] overflow_counter;
  logic [4:0]  fifo_level;

  adc_sample_decimator_if axis ();

  adc_sample_decimator dut (
    .aclk             (aclk),
    .areset           (areset),
    .adc_data         (adc_data),
    .adc_valid        (adc_valid),
    .config_reg       (config_reg),
    .m_axis           (axis),
    .overflow_counter (overflow_counter),
    .fifo_level       (fifo_level)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input int v);
    @(negedge aclk);
    adc_data  = 18'(v);
    adc_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge aclk);
    adc_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    areset      = 1'b1;
    adc_data    = '0;
    adc_valid   = 1'b0;
    config_reg  = '0;
    axis.tready = 1'b0;
    #12;
    chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
    chk("rst_tdata", axis.tdata, 32'd0);
    chk("rst_ovf", overflow_counter, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    @(negedge aclk);
    areset = 1'b0;

    // averaging 4,8,12,16 with k=2
    config_reg  = EN | 32'd2;
    axis.tready = 1'b1;
    send(4); send(8); send(12); send(16);
    chk("avg_early_tvalid", 32'(axis.tvalid), 32'd0);
    idle();
    chk("avg_tvalid", 32'(axis.tvalid), 32'd1);
    chk("avg_tdata", axis.tdata, 32'h0000_000A);
    chk("avg_level", 32'(fifo_level), 32'd1);
    idle();
    chk("avg_drained", 32'(axis.tvalid), 32'd0);

    // floor of -11/4 and sign extension
    send(-3); send(-3); send(-3); send(-2);
    idle();
    chk("floor_tdata", axis.tdata, 32'hFFFF_FFFD);
    config_reg = EN;
    send(32'h20000);
    idle();
    chk("pass_neg_tdata", axis.tdata, 32'hFFFE_0000);

    // overflow: 20 pushes into 16 entries
    idle();
    axis.tready = 1'b0;
    for (int i = 0; i < 20; i++) send(i);
    idle();
    chk("ovf_level", 32'(fifo_level), 32'd16);
    chk("ovf_count", overflow_counter, 32'd4);
    chk("ovf_head", axis.tdata, 32'd0);
    axis.tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), axis.tdata, 32'(i));
      @(negedge aclk);
    end
    chk("drain_tvalid_low", 32'(axis.tvalid), 32'd0);
    chk("drain_level", 32'(fifo_level), 32'd0);

    // full FIFO with simultaneous push and pop
    axis.tready = 1'b0;
    for (int i = 0; i < 16; i++) send(i);
    idle();
    chk("full_level", 32'(fifo_level), 32'd16);
    send(50);
    axis.tready = 1'b1;
    idle();
    axis.tready = 1'b0;
    chk("pp_level", 32'(fifo_level), 32'd16);
    chk("pp_ovf", overflow_counter, 32'd4);
    chk("pp_head", axis.tdata, 32'd1);
    axis.tready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("pp_drain_%0d", i), axis.tdata, 32'(i));
      @(negedge aclk);
    end
    chk("pp_drain_last", axis.tdata, 32'd50);
    @(negedge aclk);
    chk("pp_empty", 32'(axis.tvalid), 32'd0);

    // k field 15 clamps to 12
    config_reg = EN | 32'd15;
    for (int i = 0; i < 4095; i++) send(7);
    chk("clamp_pending", 32'(axis.tvalid), 32'd0);
    send(7);
    idle();
    chk("clamp_tvalid", 32'(axis.tvalid), 32'd1);
    chk("clamp_tdata", axis.tdata, 32'd7);
    idle();

    // k change mid-block applies to the next block
    config_reg = EN | 32'd2;
    send(1); send(2); send(3);
    config_reg = EN | 32'd1;
    send(4);
    idle();
    chk("kchg_old", axis.tdata, 32'd2);
    idle();
    send(6); send(8);
    idle();
    chk("kchg_new", axis.tdata, 32'd7);
    idle();

    // disable mid-block
    config_reg  = EN | 32'd2;
    axis.tready = 1'b0;
    send(40); send(40); send(40); send(40);
    send(1); send(2);
    send(99);
    config_reg = 32'd2;
    send(10);
    config_reg = EN | 32'd2;
    send(20); send(30); send(40);
    idle();
    chk("dis_level", 32'(fifo_level), 32'd2);
    chk("dis_first", axis.tdata, 32'd40);
    axis.tready = 1'b1;
    @(negedge aclk);
    chk("dis_second", axis.tdata, 32'd25);
    @(negedge aclk);
    chk("dis_empty", 32'(axis.tvalid), 32'd0);

    // reset mid-block with three words queued
    axis.tready = 1'b0;
    config_reg  = EN;
    send(5); send(6); send(7);
    send(1);
    config_reg = EN | 32'd2;
    send(2);
    idle();
    chk("prerst_level", 32'(fifo_level), 32'd3);
    #2;
    areset = 1'b1;
    #1;
    chk("inrst_tvalid", 32'(axis.tvalid), 32'd0);
    chk("inrst_tdata", axis.tdata, 32'd0);
    chk("inrst_level", 32'(fifo_level), 32'd0);
    chk("inrst_ovf", overflow_counter, 32'd0);
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    chk("postrst_tvalid", 32'(axis.tvalid), 32'd0);
    axis.tready = 1'b1;
    send(100); send(200); send(300); send(400);
    idle();
    chk("postrst_tdata", axis.tdata, 32'd250);
    chk("postrst_level", 32'(fifo_level), 32'd1);
    idle();
    chk("postrst_empty", 32'(axis.tvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
